// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, register
// constants and the stage-control bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Enable bundle, ordered PC first down to the last pipeline register.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_exe;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  // The PC has no flush, so the flush bundle covers the stage registers only.
  typedef struct packed {
    logic if_id;
    logic id_exe;
    logic ex_mem;
    logic mem_wb;
  } stage_flush_t;

  localparam stage_en_t    EN_ALL    = 5'b11111;
  localparam stage_en_t    EN_NONE   = 5'b00000;
  localparam stage_flush_t FLUSH_ALL = 4'b1111;
  localparam stage_flush_t FLUSH_NONE = 4'b0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, redirect flushes,
// data-memory freeze and ecall halt for the 5-stage pipe.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             wb_ecall,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_exe_en,
  output logic             id_exe_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t       state, state_nxt;
  stage_en_t    en;
  stage_flush_t flush;
  logic         load_use, stall_inc, flush_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  assign load_use = ex_mem_to_reg && ex_reg_write && (ex_rd_addr != REG_X0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    state_nxt = state;
    en        = EN_NONE;
    flush     = FLUSH_NONE;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      // Clear every stage register to a NOP while reset is held.
      flush     = FLUSH_ALL;
      state_nxt = RUN;
    end else begin
      case (state)
        HALT: if (resume) state_nxt = RUN;
        RUN, MEM_WAIT: begin
          if (wb_ecall) begin
            en.mem_wb = 1'b1;
            state_nxt = HALT;
          end else if (dmem_req && !dmem_ready) begin
            state_nxt = MEM_WAIT;
          end else begin
            // Leaving MEM_WAIT costs no bubble: this cycle is a normal RUN cycle.
            state_nxt = RUN;
            if (ex_redirect) begin
              en           = EN_ALL;
              flush.if_id  = 1'b1;
              flush.id_exe = 1'b1;
              flush_inc    = 1'b1;
            end else if (load_use) begin
              en           = '{pc: 1'b0, if_id: 1'b0, id_exe: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
              flush.id_exe = 1'b1;
              stall_inc    = 1'b1;
            end else begin
              en = EN_ALL;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign pc_en        = en.pc;
  assign if_id_en     = en.if_id;
  assign id_exe_en    = en.id_exe;
  assign ex_mem_en    = en.ex_mem;
  assign mem_wb_en    = en.mem_wb;
  assign if_id_flush  = flush.if_id;
  assign id_exe_flush = flush.id_exe;
  assign ex_mem_flush = flush.ex_mem;
  assign mem_wb_flush = flush.mem_wb;
  assign halted       = (state == HALT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a rule-level model checked every
// negedge, plus literal expectations at key points of the sequence.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_mem_to_reg, ex_reg_write;
  logic       ex_redirect, dmem_req, dmem_ready, wb_ecall, resume;

  logic        pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
  logic        ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_exe_en, s_id_exe_flush;
  logic        s_ex_mem_en, s_ex_mem_flush, s_mem_wb_en, s_mem_wb_flush, s_halted;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .wb_ecall(wb_ecall), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_exe_en(id_exe_en), .id_exe_flush(id_exe_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy sharing all inputs, used for saturation.
  pipeline_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .wb_ecall(wb_ecall), .resume(resume),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
    .id_exe_en(s_id_exe_en), .id_exe_flush(s_id_exe_flush),
    .ex_mem_en(s_ex_mem_en), .ex_mem_flush(s_ex_mem_flush),
    .mem_wb_en(s_mem_wb_en), .mem_wb_flush(s_mem_wb_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: mode 0 = running, 1 = waiting on memory, 2 = halted. Counters are
  // unbounded event counts, clamped to each counter width when compared.
  int m_mode, m_stall, m_flush;
  int p_mode, p_stall, p_flush;
  logic [8:0] e_out, d_out, s_out;
  logic       e_halt, lu;

  function automatic int clamp(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(negedge clk) begin
    // e_out = {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
    //          ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush}
    e_out  = 9'b0;
    e_halt = 1'b0;
    p_mode = m_mode; p_stall = m_stall; p_flush = m_flush;
    lu = ex_mem_to_reg && ex_reg_write && ex_rd_addr != 0 &&
         ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
    if (rst) begin
      e_out  = 9'b0_01_01_01_01;
      p_mode = 0; p_stall = 0; p_flush = 0;
    end else if (m_mode == 2) begin
      e_halt = 1'b1;
      if (resume) p_mode = 0;
    end else if (wb_ecall) begin
      e_out  = 9'b0_00_00_00_10;
      p_mode = 2;
    end else if (dmem_req && !dmem_ready) begin
      p_mode = 1;
    end else begin
      p_mode = 0;
      if (ex_redirect) begin
        e_out = 9'b1_11_11_10_10;
        p_flush = m_flush + 1;
      end else if (lu) begin
        e_out = 9'b0_00_11_10_10;
        p_stall = m_stall + 1;
      end else begin
        e_out = 9'b1_10_10_10_10;
      end
    end
    d_out = {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
             ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};
    s_out = {s_pc_en, s_if_id_en, s_if_id_flush, s_id_exe_en, s_id_exe_flush,
             s_ex_mem_en, s_ex_mem_flush, s_mem_wb_en, s_mem_wb_flush};
    chk("ctrl", 32'(d_out), 32'(e_out));
    chk("ctrl_w2", 32'(s_out), 32'(e_out));
    chk("halted", 32'(halted), 32'(e_halt));
    chk("stall_cnt", 32'(stall_cnt), 32'(clamp(m_stall, 65535)));
    chk("flush_cnt", 32'(flush_cnt), 32'(clamp(m_flush, 65535)));
    chk("stall_cnt_w2", 32'(s_stall_cnt), 32'(clamp(m_stall, 3)));
    chk("flush_cnt_w2", 32'(s_flush_cnt), 32'(clamp(m_flush, 3)));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_mode = p_mode; m_stall = p_stall; m_flush = p_flush;
    end
  end

  task automatic clr();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; ex_mem_to_reg = 0; ex_reg_write = 0;
    ex_redirect = 0; dmem_req = 0; dmem_ready = 0; wb_ecall = 0; resume = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd_addr = rd;
    id_rs2_addr = 5; id_rs2_used = 1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    // Reset held under live traffic.
    set_lu(5); ex_redirect = 1;
    #3;
    chk("rst_en", 32'({pc_en, if_id_en, id_exe_en, ex_mem_en, mem_wb_en}), 32'h0);
    chk("rst_flush", 32'({if_id_flush, id_exe_flush, ex_mem_flush, mem_wb_flush}), 32'hf);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    cyc(3); rst = 0; clr(); #2;
    chk("post_rst_en", 32'({pc_en, if_id_en, id_exe_en, ex_mem_en, mem_wb_en}), 32'h1f);

    // Load-use via rs2, then the load moves on.
    cyc(1); set_lu(5); #2;
    chk("lu_resp", 32'({pc_en, if_id_en, id_exe_flush, ex_mem_en, mem_wb_en}), 32'b00111);
    cyc(1); clr(); #2;
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_after", 32'(pc_en), 32'd1);
    // x0 destination: no stall.
    cyc(1); set_lu(0); id_rs2_addr = 0; #2;
    chk("x0_no_stall", 32'(pc_en), 32'd1);
    // Load-use via rs1.
    cyc(1); clr(); ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd_addr = 7; id_rs1_addr = 7; id_rs1_used = 1; #2;
    chk("lu_rs1", 32'(if_id_en), 32'd0);
    // Matching rs1 that is not read: no stall.
    cyc(1); id_rs1_used = 0; #2;
    chk("lu_unused", 32'(pc_en), 32'd1);
    // Matching rd but not a load: no stall.
    cyc(1); id_rs1_used = 1; ex_mem_to_reg = 0; #2;
    chk("lu_noload", 32'(pc_en), 32'd1);

    // Redirect beats a simultaneous load-use.
    cyc(1); clr(); set_lu(5); ex_redirect = 1; #2;
    chk("redir_resp", 32'({pc_en, if_id_flush, id_exe_flush}), 32'b111);
    cyc(1); clr(); #2;
    chk("redir_fcnt", 32'(flush_cnt), 32'd1);
    chk("redir_scnt", 32'(stall_cnt), 32'd2);

    // Memory freeze with redirect held, then redirect fires on ready.
    cyc(1); dmem_req = 1; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("freeze_en", 32'({pc_en, if_id_en, id_exe_en, ex_mem_en, mem_wb_en}), 32'h0);
      chk("freeze_flush", 32'({if_id_flush, id_exe_flush, ex_mem_flush, mem_wb_flush}), 32'h0);
      cyc(1);
    end
    dmem_ready = 1; #2;
    chk("ready_redir", 32'({pc_en, if_id_flush, id_exe_flush}), 32'b111);
    cyc(1); clr(); #2;
    chk("ready_fcnt", 32'(flush_cnt), 32'd2);
    chk("ready_run", 32'(pc_en), 32'd1);

    // ecall retirement, 10 halted cycles with junk inputs, resume.
    cyc(1); wb_ecall = 1; #2;
    chk("ecall_en", 32'({pc_en, if_id_en, id_exe_en, ex_mem_en, mem_wb_en}), 32'b00001);
    chk("ecall_halted", 32'(halted), 32'd0);
    cyc(1); wb_ecall = 0; set_lu(5); ex_redirect = 1; dmem_req = 1;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("halt_state", 32'({halted, pc_en, mem_wb_en}), 32'b100);
      cyc(1);
    end
    resume = 1; #2;
    chk("resume_frozen", 32'({halted, pc_en, if_id_flush}), 32'b100);
    cyc(1); clr(); #2;
    chk("resume_run", 32'({halted, pc_en, if_id_en, mem_wb_en}), 32'b0111);
    chk("halt_fcnt", 32'(flush_cnt), 32'd2);

    // Five more load-use bubbles: narrow counter pins at all-ones.
    for (int i = 0; i < 5; i++) begin
      cyc(1); set_lu(5);
      cyc(1); clr();
    end
    #2;
    chk("sat_w2", 32'(s_stall_cnt), 32'd3);
    chk("sat_w16", 32'(stall_cnt), 32'd7);

    // Reset asserted while halted returns to RUN at once.
    cyc(1); wb_ecall = 1;
    cyc(1); wb_ecall = 0; #2;
    chk("pre_rst_halt", 32'(halted), 32'd1);
    #1 rst = 1;
    #1;
    chk("mid_rst_halt", 32'(halted), 32'd0);
    chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    cyc(1); rst = 0; #2;
    chk("mid_rst_run", 32'({pc_en, if_id_en, id_exe_en, ex_mem_en, mem_wb_en}), 32'h1f);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives enable and flush of IF_ID, ID_EXE, EX_MEM and MEM_WB, plus the PC enable.
- Detects load-use hazards, flushes wrong-path instructions on taken branches and jumps, freezes the pipe during data-memory wait, and halts on ecall retirement.
- Sits at top level beside the stage registers. Stage registers treat flush as a synchronous clear to 0 (NOP) that dominates en.

Parameters:
CNT_W, 16, width of the saturating performance counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_rs1_addr  in  5  rs1 of the instruction in ID
- id_rs2_addr  in  5  rs2 of the instruction in ID
- id_rs1_used  in  1  instruction in ID reads rs1
- id_rs2_used  in  1  instruction in ID reads rs2
- ex_mem_to_reg  in  1  instruction in EX is a load
- ex_reg_write  in  1  instruction in EX writes rd
- ex_rd_addr  in  5  rd of the instruction in EX
- ex_redirect  in  1  taken beq/bne, or jal/jalr, resolved in EX
- dmem_req  in  1  MEM stage accesses data memory this cycle
- dmem_ready  in  1  data memory completes the access
- wb_ecall  in  1  ecall is retiring in WB
- resume  in  1  single-cycle pulse that leaves HALT
- pc_en  out  1  PC update enable
- if_id_en, if_id_flush  out  1 each
- id_exe_en, id_exe_flush  out  1 each
- ex_mem_en, ex_mem_flush  out  1 each
- mem_wb_en, mem_wb_flush  out  1 each
- halted  out  1  FSM is in HALT
- stall_cnt  out  CNT_W  load-use bubbles inserted (saturating)
- flush_cnt  out  CNT_W  redirects taken (saturating)

Behaviour:

FSM states (2-bit encoding): RUN=0, MEM_WAIT=1, HALT=2. Reset and encoding 3 both go to RUN.

Reset:
- state=RUN, counters=0.
- While rst is high, all en=0, all flush=1, and halted=0. This clears every stage register.

Outputs are Mealy, combinational from state and inputs. Conditions are evaluated in this priority order:

1. state==HALT: all en=0, all flush=0, pc_en=0, halted=1.
   - resume=1 moves to RUN. Outputs stay frozen in that cycle; RUN behaviour starts the next cycle.
   - All other inputs are ignored.
2. wb_ecall=1 while in RUN or MEM_WAIT: the retiring instruction is allowed to write back (mem_wb_en unaffected).
   - Next state is HALT. All other en=0 and pc_en=0 this cycle.
3. Memory freeze, when dmem_req=1 and dmem_ready=0, in either state: all en=0, pc_en=0, flushes=0.
   - RUN moves to MEM_WAIT.
   - MEM_WAIT holds.
   - ex_redirect and the load-use check are suppressed. They are re-evaluated after the freeze.
4. MEM_WAIT with dmem_ready=1: go to RUN. This cycle behaves as RUN (rules 5–7 apply). Wait latency equals memory latency; there is no extra bubble.
5. ex_redirect=1: pc_en=1, all en=1, if_id_flush=1, id_exe_flush=1, flush_cnt+1.
   - Redirect overrides load-use, because the ID instruction is on the wrong path.
6. Load-use hazard, defined as ex_mem_to_reg & ex_reg_write & ex_rd_addr!=0 & ((id_rs1_used & rs1==rd) | (id_rs2_used & rs2==rd)).
   - Response: pc_en=0, if_id_en=0, id_exe_flush=1 (bubble), ex_mem_en=1, mem_wb_en=1, stall_cnt+1.
   - Exactly one bubble: the next cycle the load sits in MEM and the hazard term is false.
7. Otherwise: all en=1, all flush=0, pc_en=1.

Other rules:
- x0 never creates a hazard.
- Counters saturate at all-ones and never wrap.
- A reset asserted mid-operation (MEM_WAIT or HALT) returns to RUN immediately.
- halted is set only from state; it never depends on a combinational path from inputs.

Decomposition:
- Shared package pipe_pkg holds:
  - the state localparams (RUN, MEM_WAIT, HALT), 2 bits wide;
  - REG_X0 = 5'd0;
  - the stage-control bundle ordering {pc, if_id, id_exe, ex_mem, mem_wb}.
- One sub-module is natural: sat_counter (CNT_W, inc). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
1. Reset: rst=1 during traffic → all flush=1, all en=0, halted=0, counters=0. After release with no hazard, all en=1.
2. Load-use: ex_mem_to_reg=1, ex_reg_write=1, ex_rd_addr=5, id_rs2_addr=5, id_rs2_used=1 → one cycle of pc_en=0, if_id_en=0, id_exe_flush=1; stall_cnt=1. The next cycle (load moved on) returns to normal. Repeating with ex_rd_addr=0 → no stall.
3. Redirect plus simultaneous load-use → if_id_flush=1, id_exe_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
4. Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, with ex_redirect=1 held → 3 frozen cycles (all en=0, no flush). Then ready=1 → the redirect flush fires in that same cycle, and state returns to RUN.
5. ecall: wb_ecall=1 → mem_wb_en=1 and other en=0, then halted=1 from the next cycle. Holds 10 cycles; resume pulse → one more frozen cycle, then normal.
6. Saturation: CNT_W=2 with 5 load-use hazards → stall_cnt=3.
